instruction_memory: RTL and testbench
=====================================

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter DATA_W, default 16: instruction word width in bits.
REQ-002 Parameter ADDR_W, default 16: address bus width in bits.
REQ-003 Parameter DEPTH, default 256: number of addressable words, indexed 0..DEPTH-1.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port addr, input, ADDR_W bits: word address; not byte address, one word per increment.
REQ-007 Port instruction, output, DATA_W bits: registered instruction word read from addr.

Function
REQ-008 The memory SHALL be read-only, with contents fixed by a constant program image; no write port.
REQ-009 Program image words SHALL be: 0 = 16'h7A01, 1 = 16'h7B02, 2 = 16'h1AB0, 3 = 16'h2AB0, 4 = 16'h3C00, 5 = 16'h8C10, 6 = 16'h9C20, 7 = 16'hF000.
REQ-010 Locations 8..DEPTH-1 SHALL read 16'h0000 (NOP).
REQ-011 On each rising clk edge with rst low, instruction SHALL load the word at addr; read latency is exactly one cycle.
REQ-012 For addr >= DEPTH, the loaded value SHALL be 16'h0000; no wrap-around or aliasing of upper address bits.
REQ-013 instruction SHALL hold its value between edges and SHALL NOT change combinationally with addr.
REQ-014 If addr is stable, instruction SHALL stay constant on every later cycle.
REQ-015 Back-to-back address changes on consecutive cycles SHALL each produce their word one cycle later, with no bubbles.

Reset
REQ-016 When rst is high at a rising clk edge, instruction SHALL become 16'h0000, whatever the value of addr.
REQ-017 Reset SHALL have priority over a read in the same cycle.
REQ-018 Reset asserted mid-operation SHALL clear instruction on the next edge.
REQ-019 On the first edge after rst deasserts, instruction SHALL load from the current addr.
REQ-020 Memory contents SHALL be unaffected by reset.
REQ-021 instruction is undefined before the first clocked reset; benches SHALL apply reset first.

Structure
REQ-022 A shared package SHALL hold DATA_W/ADDR_W defaults, the NOP constant 16'h0000, PROG_LEN = 8, and the program-image constant array.
REQ-023 The design SHALL be one module, with no sub-module.
REQ-024 The image SHALL be implemented as a constant lookup (case or initialised constant array) feeding a single output register with synchronous clear.

Verification
REQ-025 Reset: hold rst=1 for 3 cycles with addr=3 -> instruction=16'h0000 throughout.
REQ-026 Sequential read: release rst, drive addr 0..7 one per cycle -> instruction is 7A01, 7B02, 1AB0, 2AB0, 3C00, 8C10, 9C20, F000, each one cycle after its address.
REQ-027 Unprogrammed and out-of-range reads: addr=8 -> 16'h0000; addr=255 -> 16'h0000; addr=16'h0100 -> 16'h0000, with no alias to word 0.
REQ-028 Mid-operation reset: addr=5 and instruction=8C10, assert rst for 1 cycle -> 0000; deassert -> 8C10 on the next edge.
REQ-029 Latency: change addr from 1 to 2 -> instruction stays 7B02 until the next rising edge, then becomes 1AB0.
REQ-030 Hold: keep addr=7 for 10 cycles -> instruction stays F000.

Source files
------------

// File: rtl/instruction_memory_pkg.sv
// Shared constants for the instruction memory: default bus widths, the NOP
// encoding and the fixed program image.
package instruction_memory_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DEPTH  = 256;

   // Encoding returned for unprogrammed or out-of-range locations.
   localparam logic [15:0] NOP = 16'h0000;

   // Number of words in the program image; its index width is derived from it.
   localparam int PROG_LEN   = 8;
   localparam int PROG_IDX_W = $clog2(PROG_LEN);

   // Program image, element 0 is the word at address 0.
   localparam logic [PROG_LEN-1:0][15:0] PROG_IMAGE = {
      16'hF000,   // 7
      16'h9C20,   // 6
      16'h8C10,   // 5
      16'h3C00,   // 4
      16'h2AB0,   // 3
      16'h1AB0,   // 2
      16'h7B02,   // 1
      16'h7A01    // 0
   };

   // Word stored at a given image index.
   function automatic logic [15:0] prog_word(input logic [PROG_IDX_W-1:0] idx);
      return PROG_IMAGE[idx];
   endfunction

endpackage

// File: rtl/instruction_memory.sv
// Read-only instruction memory: a constant program image looked up from the
// word address and captured in a single output register with synchronous clear.
module instruction_memory
   import instruction_memory_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] instruction
);

   // Bounds held one bit wider than the address so that the full address
   // range compares without truncation; upper address bits never alias.
   localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] PROG_LEN_L = (ADDR_W+1)'(PROG_LEN);

   logic [ADDR_W:0]     addr_ext;
   logic                in_image;
   logic [DATA_W-1:0]   rom_word;
   logic [DATA_W-1:0]   instruction_d;
   logic [DATA_W-1:0]   instruction_q;

   assign addr_ext = {1'b0, addr};

   // Constant lookup: image words below PROG_LEN (and below DEPTH), NOP elsewhere.
   always_comb begin
      in_image = (addr_ext < PROG_LEN_L) && (addr_ext < DEPTH_L);
      rom_word = DATA_W'(NOP);
      if (in_image) begin
         rom_word = DATA_W'(prog_word(addr[PROG_IDX_W-1:0]));
      end
   end

   // Next value of the output register is simply the looked-up word.
   always_comb begin
      instruction_d = rom_word;
   end

   // Output register; reset wins over the read in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         instruction_q <= DATA_W'(NOP);
      end else begin
         instruction_q <= instruction_d;
      end
   end

   assign instruction = instruction_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: scoreboard queue of expected
// output words, filled when a cycle is driven and drained after the edge.
module tb_instruction_memory;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int DEPTH  = 256;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] instruction;

   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] last_exp;
   bit                last_valid;
   int                n_checks;
   int                n_fail;

   // Reference program image, written independently of the design package.
   logic [15:0] ref_img [8];

   instruction_memory #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .instruction(instruction)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "timeout");
   end

   function automatic logic [DATA_W-1:0] model(input logic r, input logic [ADDR_W-1:0] a);
      if (r) return 16'h0000;
      if (a < 8) return ref_img[a[2:0]];
      return 16'h0000;
   endfunction

   task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle: inputs change on the falling edge, the output must not
   // follow them before the rising edge, and the new word appears just after.
   task automatic drive_cycle(input logic r, input logic [ADDR_W-1:0] a, input string tag);
      @(negedge clk);
      rst  = r;
      addr = a;
      exp_q.push_back(model(r, a));
      #1;
      if (last_valid) check_eq({tag, "_hold"}, instruction, last_exp);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check_eq({tag, "_queue"}, 16'hxxxx, 16'h0000);
      end else begin
         last_exp = exp_q.pop_front();
         last_valid = 1'b1;
         check_eq(tag, instruction, last_exp);
      end
   endtask

   initial begin
      ref_img[0] = 16'h7A01; ref_img[1] = 16'h7B02;
      ref_img[2] = 16'h1AB0; ref_img[3] = 16'h2AB0;
      ref_img[4] = 16'h3C00; ref_img[5] = 16'h8C10;
      ref_img[6] = 16'h9C20; ref_img[7] = 16'hF000;
      n_checks   = 0;
      n_fail     = 0;
      last_valid = 1'b0;
      last_exp   = '0;
      rst        = 1'b1;
      addr       = 16'd3;

      // Reset held for three cycles with a programmed address present
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 16'd3, "reset");

      // Sequential read of the whole image, back to back
      for (int i = 0; i < 8; i++) drive_cycle(1'b0, 16'(i), "seq_read");

      // Unprogrammed and out-of-range addresses
      drive_cycle(1'b0, 16'd8,     "unprog_8");
      drive_cycle(1'b0, 16'd255,   "unprog_255");
      drive_cycle(1'b0, 16'h0100,  "oor_0100");
      drive_cycle(1'b0, 16'h0105,  "oor_0105");
      drive_cycle(1'b0, 16'hFFFF,  "oor_ffff");
      drive_cycle(1'b0, 16'h8001,  "oor_8001");

      // Mid-operation reset
      drive_cycle(1'b0, 16'd5, "mid_pre");
      drive_cycle(1'b1, 16'd5, "mid_rst");
      drive_cycle(1'b0, 16'd5, "mid_post");

      // Latency: address 1 then 2, old word held until the edge
      drive_cycle(1'b0, 16'd1, "lat_a1");
      drive_cycle(1'b0, 16'd2, "lat_a2");

      // Stable address holds its word
      for (int i = 0; i < 10; i++) drive_cycle(1'b0, 16'd7, "hold_7");

      // Random reads, mostly near the image, some across the full range
      for (int i = 0; i < 40; i++) drive_cycle(1'b0, 16'($urandom_range(0, 15)), "rand_lo");
      for (int i = 0; i < 20; i++) drive_cycle(1'b0, 16'($urandom_range(0, 65535)), "rand_full");

      // Random reset pulses interleaved with reads
      for (int i = 0; i < 20; i++)
         drive_cycle(($urandom_range(0, 3) == 0), 16'($urandom_range(0, 9)), "rand_rst");

      check_eq("queue_empty", 16'(exp_q.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
